// File: rtl/execute_operand_stage_pkg.sv
// Shared control types for the ID/EX operand stage and its forwarding muxes.
package execute_operand_stage_pkg;

  // ALU operation encoding shared with the ALU.
  typedef enum logic [2:0] {
    OP_SUB = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b011,
    OP_ADD = 3'b111
  } aluOperation_t;

  // Which bus supplied an operand.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } forwardSel_t;

endpackage

// File: rtl/execute_operand_stage_forward_select.sv
// Forwarding mux for one source operand: EX/MEM beats MEM/WB, x0 is never forwarded.
module execute_operand_stage_forward_select
  import execute_operand_stage_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 5
) (
  input  logic [AddrWidth-1:0] src_addr,
  input  logic [DataWidth-1:0] src_data,
  input  logic                 ex_mem_reg_write,
  input  logic [AddrWidth-1:0] ex_mem_rd,
  input  logic [DataWidth-1:0] ex_mem_result,
  input  logic                 mem_wb_reg_write,
  input  logic [AddrWidth-1:0] mem_wb_rd,
  input  logic [DataWidth-1:0] mem_wb_result,
  output forwardSel_t          sel,
  output logic [DataWidth-1:0] data
);

  // Priority select of the newest producer of src_addr.
  always_comb begin
    sel  = FWD_NONE;
    data = src_data;
    if (src_addr != '0) begin
      if (ex_mem_reg_write && (ex_mem_rd == src_addr)) begin
        sel  = FWD_EXMEM;
        data = ex_mem_result;
      end else if (mem_wb_reg_write && (mem_wb_rd == src_addr)) begin
        sel  = FWD_MEMWB;
        data = mem_wb_result;
      end
    end
  end

endmodule

// File: rtl/execute_operand_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding at capture and while held.
module execute_operand_stage
  import execute_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_POW = 6,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  localparam int unsigned DataWidth = 1 << DATA_WIDTH_POW
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      idValid_in,
  output logic                      idReady_out,
  input  logic [REG_ADDR_WIDTH-1:0] rs1Addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs2Addr_in,
  input  logic [DataWidth-1:0]      rs1Data_in,
  input  logic [DataWidth-1:0]      rs2Data_in,
  input  logic [DataWidth-1:0]      imm_in,
  input  logic                      aluSrcImm_in,
  input  aluOperation_t             aluOp_in,
  input  logic [REG_ADDR_WIDTH-1:0] rdAddr_in,
  input  logic                      regWrite_in,
  input  logic                      exMemRegWrite_in,
  input  logic [REG_ADDR_WIDTH-1:0] exMemRd_in,
  input  logic [DataWidth-1:0]      exMemResult_in,
  input  logic                      memWbRegWrite_in,
  input  logic [REG_ADDR_WIDTH-1:0] memWbRd_in,
  input  logic [DataWidth-1:0]      memWbResult_in,
  input  logic                      flush_in,
  input  logic                      exReady_in,
  output logic                      exValid_out,
  output logic [DataWidth-1:0]      operand1_out,
  output logic [DataWidth-1:0]      operand2_out,
  output aluOperation_t             aluOp_out,
  output logic [REG_ADDR_WIDTH-1:0] rdAddr_out,
  output logic                      regWrite_out
);

  logic                      valid_q, valid_d;
  logic                      reg_write_q, reg_write_d;
  logic                      imm_q, imm_d;
  logic [DataWidth-1:0]      op1_q, op1_d, op2_q, op2_d;
  aluOperation_t             alu_op_q, alu_op_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;

  logic accept, capture, snoop;
  logic [REG_ADDR_WIDTH-1:0] fwd1_addr, fwd2_addr;
  logic [DataWidth-1:0]      fwd1_in, fwd2_in, fwd1_data, fwd2_data;
  forwardSel_t               fwd1_sel, fwd2_sel;

  assign idReady_out = ~valid_q | exReady_in;
  assign accept      = idValid_in & idReady_out;
  assign capture     = accept & ~flush_in;
  // Snoop only when stalled; idReady is low then, so it never overlaps a capture.
  assign snoop       = valid_q & ~exReady_in & ~flush_in;

  // The same muxes serve capture (decode inputs) and snoop (stored index and operand).
  assign fwd1_addr = snoop ? rs1_q : rs1Addr_in;
  assign fwd2_addr = snoop ? rs2_q : rs2Addr_in;
  assign fwd1_in   = snoop ? op1_q : rs1Data_in;
  assign fwd2_in   = snoop ? op2_q : rs2Data_in;

  execute_operand_stage_forward_select #(
    .DataWidth(DataWidth),
    .AddrWidth(REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .src_addr        (fwd1_addr),
    .src_data        (fwd1_in),
    .ex_mem_reg_write(exMemRegWrite_in),
    .ex_mem_rd       (exMemRd_in),
    .ex_mem_result   (exMemResult_in),
    .mem_wb_reg_write(memWbRegWrite_in),
    .mem_wb_rd       (memWbRd_in),
    .mem_wb_result   (memWbResult_in),
    .sel             (fwd1_sel),
    .data            (fwd1_data)
  );

  execute_operand_stage_forward_select #(
    .DataWidth(DataWidth),
    .AddrWidth(REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .src_addr        (fwd2_addr),
    .src_data        (fwd2_in),
    .ex_mem_reg_write(exMemRegWrite_in),
    .ex_mem_rd       (exMemRd_in),
    .ex_mem_result   (exMemResult_in),
    .mem_wb_reg_write(memWbRegWrite_in),
    .mem_wb_rd       (memWbRd_in),
    .mem_wb_result   (memWbResult_in),
    .sel             (fwd2_sel),
    .data            (fwd2_data)
  );

  // Next-state: flush > capture > snoop > consume > hold.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    imm_d       = imm_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    if (flush_in) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      reg_write_d = regWrite_in;
      imm_d       = aluSrcImm_in;
      op1_d       = fwd1_data;
      op2_d       = aluSrcImm_in ? imm_in : fwd2_data;
      alu_op_d    = aluOp_in;
      rd_d        = rdAddr_in;
      rs1_d       = rs1Addr_in;
      rs2_d       = rs2Addr_in;
    end else if (snoop) begin
      if (fwd1_sel != FWD_NONE) op1_d = fwd1_data;
      if (!imm_q && (fwd2_sel != FWD_NONE)) op2_d = fwd2_data;
    end else if (valid_q && exReady_in) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      imm_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_op_q    <= OP_ADD;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      imm_q       <= imm_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end

  assign exValid_out  = valid_q;
  assign operand1_out = op1_q;
  assign operand2_out = op2_q;
  assign aluOp_out    = alu_op_q;
  assign rdAddr_out   = rd_q;
  assign regWrite_out = reg_write_q & valid_q;

endmodule

// File: tb/tb_execute_operand_stage.sv
// Scoreboard bench for execute_operand_stage: expectations queued at drive, checked after edge.
module tb_execute_operand_stage;
  import execute_operand_stage_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_in, idValid_in, idReady_out, aluSrcImm_in, regWrite_in;
  logic [AW-1:0] rs1Addr_in, rs2Addr_in, rdAddr_in, exMemRd_in, memWbRd_in, rdAddr_out;
  logic [DW-1:0] rs1Data_in, rs2Data_in, imm_in, exMemResult_in, memWbResult_in;
  logic [DW-1:0] operand1_out, operand2_out;
  logic          exMemRegWrite_in, memWbRegWrite_in, flush_in, exReady_in;
  logic          exValid_out, regWrite_out;
  aluOperation_t aluOp_in, aluOp_out;

  execute_operand_stage dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .idValid_in      (idValid_in),
    .idReady_out     (idReady_out),
    .rs1Addr_in      (rs1Addr_in),
    .rs2Addr_in      (rs2Addr_in),
    .rs1Data_in      (rs1Data_in),
    .rs2Data_in      (rs2Data_in),
    .imm_in          (imm_in),
    .aluSrcImm_in    (aluSrcImm_in),
    .aluOp_in        (aluOp_in),
    .rdAddr_in       (rdAddr_in),
    .regWrite_in     (regWrite_in),
    .exMemRegWrite_in(exMemRegWrite_in),
    .exMemRd_in      (exMemRd_in),
    .exMemResult_in  (exMemResult_in),
    .memWbRegWrite_in(memWbRegWrite_in),
    .memWbRd_in      (memWbRd_in),
    .memWbResult_in  (memWbResult_in),
    .flush_in        (flush_in),
    .exReady_in      (exReady_in),
    .exValid_out     (exValid_out),
    .operand1_out    (operand1_out),
    .operand2_out    (operand2_out),
    .aluOp_out       (aluOp_out),
    .rdAddr_out      (rdAddr_out),
    .regWrite_out    (regWrite_out)
  );

  typedef struct {
    string         name;
    logic          valid;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    aluOperation_t op;
    logic [AW-1:0] rd;
    logic          rw;
    logic          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic expect_out(input string name, input logic valid, input logic [DW-1:0] op1,
                            input logic [DW-1:0] op2, input aluOperation_t op,
                            input logic [AW-1:0] rd, input logic rw, input logic chk_data);
    exp_t e;
    e.name = name; e.valid = valid; e.op1 = op1; e.op2 = op2;
    e.op = op; e.rd = rd; e.rw = rw; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  task automatic expect_reset(input string name);
    expect_out(name, 1'b0, '0, '0, OP_ADD, '0, 1'b0, 1'b1);
  endtask

  // One clock edge, then compare against the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({e.name, ".valid"}, 64'(exValid_out), 64'(e.valid));
      check_eq({e.name, ".regWrite"}, 64'(regWrite_out), 64'(e.rw));
      if (e.chk_data) begin
        check_eq({e.name, ".op1"}, operand1_out, e.op1);
        check_eq({e.name, ".op2"}, operand2_out, e.op2);
        check_eq({e.name, ".aluOp"}, 64'(aluOp_out), 64'(e.op));
        check_eq({e.name, ".rd"}, 64'(rdAddr_out), 64'(e.rd));
      end
    end
  endtask

  task automatic check_ready(input string tag, input logic want);
    #1;
    check_eq(tag, 64'(idReady_out), 64'(want));
  endtask

  task automatic set_idle();
    idValid_in = 1'b0; aluSrcImm_in = 1'b0; regWrite_in = 1'b0;
    rs1Addr_in = '0; rs2Addr_in = '0; rdAddr_in = '0;
    rs1Data_in = '0; rs2Data_in = '0; imm_in = '0; aluOp_in = OP_ADD;
    exMemRegWrite_in = 1'b0; exMemRd_in = '0; exMemResult_in = '0;
    memWbRegWrite_in = 1'b0; memWbRd_in = '0; memWbResult_in = '0;
    flush_in = 1'b0; exReady_in = 1'b1;
  endtask

  task automatic offer(input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                       input logic src_imm, input logic [DW-1:0] imm,
                       input aluOperation_t op, input logic [AW-1:0] rd, input logic rw);
    idValid_in = 1'b1;
    rs1Addr_in = a1; rs1Data_in = d1; rs2Addr_in = a2; rs2Data_in = d2;
    aluSrcImm_in = src_imm; imm_in = imm; aluOp_in = op; rdAddr_in = rd; regWrite_in = rw;
  endtask

  task automatic fwd(input logic em_w, input logic [AW-1:0] em_rd, input logic [DW-1:0] em_v,
                     input logic mw_w, input logic [AW-1:0] mw_rd, input logic [DW-1:0] mw_v);
    exMemRegWrite_in = em_w; exMemRd_in = em_rd; exMemResult_in = em_v;
    memWbRegWrite_in = mw_w; memWbRd_in = mw_rd; memWbResult_in = mw_v;
  endtask

  aluOperation_t ops[4] = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
  logic [DW-1:0] imm_neg = 64'hFFFF_FFFF_FFFF_FFF0;

  initial begin
    set_idle();
    reset_in = 1'b1;
    expect_reset("reset0"); tick();
    expect_reset("reset1"); tick();
    reset_in = 1'b0;
    check_ready("ready_after_reset", 1'b1);

    // Plain capture, no forwarding.
    offer(5'd3, 64'h10, 5'd4, 64'h20, 1'b0, '0, OP_SUB, 5'd9, 1'b1);
    expect_out("basic", 1'b1, 64'h10, 64'h20, OP_SUB, 5'd9, 1'b1, 1'b1); tick();

    // Both buses match rs1: EX/MEM wins. Previous entry consumed the same cycle.
    set_idle();
    offer(5'd5, 64'h01, 5'd6, 64'h02, 1'b0, '0, OP_AND, 5'd1, 1'b1);
    fwd(1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB);
    check_ready("ready_consume_accept", 1'b1);
    expect_out("fwd_prio", 1'b1, 64'hAA, 64'h02, OP_AND, 5'd1, 1'b1, 1'b1); tick();

    // x0 is never forwarded.
    offer(5'd0, 64'h33, 5'd0, 64'h44, 1'b0, '0, OP_OR, 5'd2, 1'b1);
    fwd(1'b1, 5'd0, 64'hAA, 1'b1, 5'd0, 64'hBB);
    expect_out("x0", 1'b1, 64'h33, 64'h44, OP_OR, 5'd2, 1'b1, 1'b1); tick();

    // Non-writing EX/MEM falls through to MEM/WB; rs2 takes EX/MEM.
    offer(5'd1, 64'h11, 5'd2, 64'h22, 1'b0, '0, OP_SUB, 5'd7, 1'b0);
    fwd(1'b0, 5'd1, 64'hAA, 1'b1, 5'd1, 64'hDD);
    exMemRegWrite_in = 1'b0;
    expect_out("fwd_mix_rs1", 1'b1, 64'hDD, 64'h22, OP_SUB, 5'd7, 1'b0, 1'b1); tick();
    offer(5'd1, 64'h11, 5'd2, 64'h22, 1'b0, '0, OP_SUB, 5'd7, 1'b1);
    fwd(1'b1, 5'd2, 64'hCC, 1'b1, 5'd1, 64'hDD);
    expect_out("fwd_mix_both", 1'b1, 64'hDD, 64'hCC, OP_SUB, 5'd7, 1'b1, 1'b1); tick();

    // Immediate ignores rs2 forwarding, both at capture and while held.
    offer(5'd10, 64'h5, 5'd11, 64'h6, 1'b1, imm_neg, OP_ADD, 5'd3, 1'b1);
    fwd(1'b0, '0, '0, 1'b1, 5'd11, 64'h77);
    expect_out("imm", 1'b1, 64'h5, imm_neg, OP_ADD, 5'd3, 1'b1, 1'b1); tick();
    set_idle(); exReady_in = 1'b0;
    fwd(1'b0, '0, '0, 1'b1, 5'd11, 64'h99);
    check_ready("ready_hold_imm", 1'b0);
    expect_out("imm_hold", 1'b1, 64'h5, imm_neg, OP_ADD, 5'd3, 1'b1, 1'b1); tick();

    // Hold three cycles, MEM/WB writes rs1 in the second.
    set_idle();
    offer(5'd7, 64'h70, 5'd12, 64'h12, 1'b0, '0, OP_SUB, 5'd4, 1'b1);
    expect_out("hold_load", 1'b1, 64'h70, 64'h12, OP_SUB, 5'd4, 1'b1, 1'b1); tick();
    offer(5'd8, 64'hDEAD, 5'd9, 64'hBEEF, 1'b0, '0, OP_OR, 5'd6, 1'b1);
    exReady_in = 1'b0;
    check_ready("ready_hold1", 1'b0);
    expect_out("hold1", 1'b1, 64'h70, 64'h12, OP_SUB, 5'd4, 1'b1, 1'b1); tick();
    fwd(1'b0, '0, '0, 1'b1, 5'd7, 64'h55);
    check_ready("ready_hold2", 1'b0);
    expect_out("hold2", 1'b1, 64'h55, 64'h12, OP_SUB, 5'd4, 1'b1, 1'b1); tick();
    fwd(1'b0, '0, '0, 1'b0, '0, '0);
    check_ready("ready_hold3", 1'b0);
    expect_out("hold3", 1'b1, 64'h55, 64'h12, OP_SUB, 5'd4, 1'b1, 1'b1); tick();

    // Flush with a valid offer while ready: offer dropped.
    exReady_in = 1'b1; flush_in = 1'b1;
    offer(5'd13, 64'hEE, 5'd14, 64'hFF, 1'b0, '0, OP_AND, 5'd5, 1'b1);
    check_ready("ready_flush", 1'b1);
    expect_out("flush", 1'b0, '0, '0, OP_ADD, '0, 1'b0, 1'b0); tick();
    set_idle();
    expect_out("flush_after", 1'b0, '0, '0, OP_ADD, '0, 1'b0, 1'b0); tick();

    // Full-throughput back-to-back stream.
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] d1, d2;
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      offer(AW'(i + 1), d1, AW'(i + 16), d2, 1'b0, '0, ops[i % 4], AW'(i + 20), 1'(i % 2));
      check_ready($sformatf("ready_b2b%0d", i), 1'b1);
      expect_out($sformatf("b2b%0d", i), 1'b1, d1, d2, ops[i % 4], AW'(i + 20), 1'(i % 2), 1'b1);
      tick();
    end

    // Consume without a new accept.
    set_idle();
    expect_out("drain", 1'b0, '0, '0, OP_ADD, '0, 1'b0, 1'b0); tick();

    // Reset mid-stream discards the entry and the simultaneous offer.
    offer(5'd2, 64'h1234, 5'd3, 64'h5678, 1'b0, '0, OP_SUB, 5'd8, 1'b1);
    expect_out("pre_reset", 1'b1, 64'h1234, 64'h5678, OP_SUB, 5'd8, 1'b1, 1'b1); tick();
    offer(5'd4, 64'h9999, 5'd5, 64'h8888, 1'b0, '0, OP_OR, 5'd9, 1'b1);
    reset_in = 1'b1;
    expect_reset("mid_reset"); tick();
    reset_in = 1'b0;
    set_idle(); exReady_in = 1'b0;
    check_ready("ready_post_reset", 1'b1);
    expect_reset("post_reset_idle"); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_operand_stage.md
Name: execute_operand_stage

Overview:
ID/EX pipeline register that sits directly upstream of the ALU and feeds its operand1_in, operand2_in and aluOp_in inputs.
- Captures decoded instructions through a valid/ready handshake.
- Resolves data hazards by forwarding from the EX/MEM and MEM/WB stages.
- Selects register or immediate for operand 2.
- Re-snoops forwarding buses while an entry is held, so held operands never go stale.

Parameters:
DATA_WIDTH_POW, 6, data width is 1 << DATA_WIDTH_POW (64 bits by default)
REG_ADDR_WIDTH, 5, register-file index width

Ports:
clk_in  input  1  clock; all state updates on its rising edge
reset_in  input  1  synchronous, active-high reset
idValid_in  input  1  decode presents a valid instruction
idReady_out  output  1  stage can accept this cycle
rs1Addr_in  input  REG_ADDR_WIDTH  source register 1 index
rs2Addr_in  input  REG_ADDR_WIDTH  source register 2 index
rs1Data_in  input  DATA_WIDTH  register-file read data 1
rs2Data_in  input  DATA_WIDTH  register-file read data 2
imm_in  input  DATA_WIDTH  sign-extended immediate
aluSrcImm_in  input  1  1 = operand 2 is the immediate
aluOp_in  input  aluOperation_t  ALU operation
rdAddr_in  input  REG_ADDR_WIDTH  destination register
regWrite_in  input  1  instruction writes rd
exMemRegWrite_in  input  1  EX/MEM stage writes a register
exMemRd_in  input  REG_ADDR_WIDTH  EX/MEM destination register
exMemResult_in  input  DATA_WIDTH  EX/MEM result
memWbRegWrite_in  input  1  MEM/WB stage writes a register
memWbRd_in  input  REG_ADDR_WIDTH  MEM/WB destination register
memWbResult_in  input  DATA_WIDTH  MEM/WB write-back data
flush_in  input  1  kill the held entry (branch redirect)
exReady_in  input  1  execute stage consumes the entry this cycle
exValid_out  output  1  held entry is valid
operand1_out  output  DATA_WIDTH  to ALU operand1_in
operand2_out  output  DATA_WIDTH  to ALU operand2_in
aluOp_out  output  aluOperation_t  to ALU aluOp_in
rdAddr_out  output  REG_ADDR_WIDTH  destination register
regWrite_out  output  1  write enable; 0 whenever exValid_out is 0

Behaviour:
- Reset (reset_in high at a clock edge):
  - exValid_out=0, operand1_out=0, operand2_out=0, aluOp_out=OP_ADD, rdAddr_out=0, regWrite_out=0.
  - Reset mid-operation discards the held entry. idReady_out is 1 in the first cycle after reset.
- Handshake:
  - idReady_out = ~exValid_out | exReady_in (combinational).
  - Accept when idValid_in & idReady_out. Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Consume: the held entry leaves when exValid_out & exReady_in. With no new accept that cycle, exValid_out drops to 0 and regWrite_out to 0.
- Forwarding at capture, per source s in {rs1, rs2}:
  - If s==0, use register data unchanged (x0 is never forwarded).
  - Else if exMemRegWrite_in & exMemRd_in==s, use exMemResult_in.
  - Else if memWbRegWrite_in & memWbRd_in==s, use memWbResult_in.
  - Else use rsXData_in.
  - EX/MEM has priority over MEM/WB.
- Operand 2 selection: if aluSrcImm_in=1, capture imm_in and ignore rs2 forwarding.
- Hold snoop: while exValid_out & ~exReady_in & ~flush_in:
  - Each operand applies the same forwarding rule against its stored source index and overwrites itself on a match.
  - Operand 2 is not snooped when the entry uses the immediate.
  - Stored rs1/rs2 indices and the imm flag are internal registers.
- Flush: flush_in has priority over accept, snoop and hold.
  - Next cycle exValid_out=0 and regWrite_out=0. Data registers may hold stale values.
  - An instruction offered in the flush cycle is dropped; idReady_out is still computed normally.
- Load-use stalls are the hazard unit's job; this stage never inserts bubbles itself.
- All widths are exact. No arithmetic is performed here.

Decomposition:
- ControlSignals package:
  - aluOperation_t (existing: OP_ADD=3'b111, OP_SUB=3'b000, OP_AND=3'b001, OP_OR=3'b011).
  - New forwardSel_t enum: FWD_NONE, FWD_EXMEM, FWD_MEMWB.
- One combinational sub-module, forward_select, instantiated twice (rs1, rs2) and reused for both capture and snoop.
  - Inputs: source index, default data, both forwarding buses.
  - Outputs: forwardSel_t and the selected data.

Test Plan:
- Reset, then accept rs1=3 (data 0x10), rs2=4 (data 0x20), OP_SUB, with no forwarding. Next cycle: exValid_out=1, operand1_out=0x10, operand2_out=0x20, aluOp_out=OP_SUB.
- rs1=5 with exMemRd=5 (0xAA) and memWbRd=5 (0xBB), both writing. Required: operand1_out=0xAA. Repeat with rs1=0: operand1_out=rs1Data_in.
- aluSrcImm=1, imm=0xFFFF_FFFF_FFFF_FFF0, memWbRd=rs2. Required: operand2_out=imm, unchanged by the forward.
- Hold with exReady_in=0 for 3 cycles, rs1=7, memWbRd=7 (0x55) writing in cycle 2. Required: operand1_out=0x55 from cycle 3 onward and idReady_out=0 throughout the hold.
- flush_in together with idValid_in=1 while an entry is held. Required: exValid_out=0 and regWrite_out=0 next cycle, and the new instruction is not captured.
- Back-to-back accepts with exReady_in=1 every cycle. Required: full throughput, one instruction per cycle. Assert reset mid-stream: all outputs return to their reset values next cycle.
